// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  localparam int UART_DW = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Integer-truncated number of system clocks in one bit period.
  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  // Width of a counter that must hold 0 .. cpb-1.
  function automatic int cnt_width(input int cpb);
    return (cpb > 1) ? $clog2(cpb) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous inputs, with a selectable reset value.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two back-to-back flops give metastability time to resolve before use.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling; feeds the seven-segment decoder.
//
// state | meaning
// IDLE  | line idle, waiting for a high-to-low edge on the synchronized line
// START | counting to mid start bit; low confirms the frame, high is a glitch
// DATA  | sampling eight data bits, one per bit period
// STOP  | sampling the stop bit; high delivers the byte, low flags a frame error
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               uart_rxd,
  output logic [UART_DW-1:0] rdata,
  output logic               rx_sig,
  output logic               frame_err,
  output logic               rx_busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CW           = cnt_width(CLKS_PER_BIT);
  localparam int IW           = $clog2(UART_DW);

  localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_TC = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(UART_DW - 1);

  if (CLKS_PER_BIT < 4) begin : g_cpb_check
    $error("uart_byte_rx: CLKS_PER_BIT must be at least 4");
  end

  uart_state_e        state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      bit_idx_q, bit_idx_d;
  logic [UART_DW-1:0] shift_q, shift_d;
  logic [UART_DW-1:0] rdata_q, rdata_d;
  logic               rx_sig_q, rx_sig_d;
  logic               frame_err_q, frame_err_d;
  logic               rx_busy_q, rx_busy_d;
  logic               rxd_d_q;
  logic               rxd_s;

  sync_2ff #(
    .WIDTH  (1),
    .RST_VAL(1'b1)
  ) u_sync_rxd (
    .clk_i(sys_clk),
    .rst_i(rst),
    .d_i  (uart_rxd),
    .q_o  (rxd_s)
  );

  // State, datapath and output registers; reset aborts any frame and clears the shown byte.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rdata_q     <= '0;
      rx_sig_q    <= 1'b0;
      frame_err_q <= 1'b0;
      rx_busy_q   <= 1'b0;
      rxd_d_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rdata_q     <= rdata_d;
      rx_sig_q    <= rx_sig_d;
      frame_err_q <= frame_err_d;
      rx_busy_q   <= rx_busy_d;
      rxd_d_q     <= rxd_s;
    end
  end

  // Next-state and datapath; the baud counter free-runs and wraps at each terminal count.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rdata_d     = rdata_q;
    rx_sig_d    = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Edge, not level: a held-low break line cannot restart a frame.
        if (!rxd_s && rxd_d_q) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_TC) begin
          cnt_d = '0;
          if (!rxd_s) begin
            bit_idx_d = '0;
            state_d   = DATA;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_q == FULL_TC) begin
          cnt_d            = '0;
          shift_d[bit_idx_q] = rxd_s;
          if (bit_idx_q == LAST_IDX) state_d = STOP;
          else bit_idx_d = bit_idx_q + IW'(1);
        end
      end
      STOP: begin
        if (cnt_q == FULL_TC) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rxd_s) begin
            rdata_d  = shift_q;
            rx_sig_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    rx_busy_d = (state_d != IDLE);
  end

  assign rdata     = rdata_q;
  assign rx_sig    = rx_sig_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = rx_busy_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx at 16 clocks per bit.
module tb_uart_byte_rx;

  localparam int CPB = 16;

  logic       sys_clk;
  logic       rst;
  logic       uart_rxd;
  logic [7:0] rdata;
  logic       rx_sig;
  logic       frame_err;
  logic       rx_busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_sig    = 0;
  int n_ferr   = 0;
  int n_both   = 0;
  int start_cyc;
  int sig_cyc_q[$];
  logic [7:0] data_q[$];

  uart_byte_rx #(
    .CLK_FREQ (1600),
    .BAUD_RATE(100)
  ) dut (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .uart_rxd (uart_rxd),
    .rdata    (rdata),
    .rx_sig   (rx_sig),
    .frame_err(frame_err),
    .rx_busy  (rx_busy)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Pulse monitor, sampled just after each rising edge.
  always @(posedge sys_clk) begin
    #1;
    if (rx_sig) begin
      n_sig++;
      sig_cyc_q.push_back(cyc);
      data_q.push_back(rdata);
    end
    if (frame_err) n_ferr++;
    if (rx_sig && frame_err) n_both++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    uart_rxd = v;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_v);
    uart_rxd = 1'b1;
  endtask

  task automatic clear_mon();
    n_sig  = 0;
    n_ferr = 0;
    sig_cyc_q.delete();
    data_q.delete();
  endtask

  initial begin
    int lat;
    rst      = 1'b1;
    uart_rxd = 1'b1;
    tick(3);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_rx_sig", rx_sig, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_busy", rx_busy, 0);
    rst = 1'b0;
    tick(5);

    // Single good byte.
    clear_mon();
    send_frame(8'h05, 1'b1);
    tick(5);
    chk("b05_nsig", n_sig, 1);
    chk("b05_rdata", rdata, 8'h05);
    chk("b05_nferr", n_ferr, 0);
    lat = (sig_cyc_q.size() > 0) ? sig_cyc_q[0] - start_cyc : -1;
    chk("b05_latency_in_154_156", (lat >= 154 && lat <= 156), 1);

    // Back-to-back frames with no idle gap.
    clear_mon();
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    tick(5);
    chk("b2b_nsig", n_sig, 2);
    if (data_q.size() >= 2) begin
      chk("b2b_first", data_q[0], 8'hA5);
      chk("b2b_second", data_q[1], 8'h3C);
      chk("b2b_spacing", sig_cyc_q[1] - sig_cyc_q[0], 160);
    end
    chk("b2b_rdata", rdata, 8'h3C);

    // Start-bit glitch: four clocks low.
    clear_mon();
    uart_rxd = 1'b0;
    tick(4);
    chk("glitch_busy_high", rx_busy, 1);
    uart_rxd = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick(1);
      if (!rx_busy) break;
    end
    chk("glitch_busy_drop", rx_busy, 0);
    tick(20);
    chk("glitch_nsig", n_sig, 0);
    chk("glitch_nferr", n_ferr, 0);

    // Bad stop bit.
    clear_mon();
    send_frame(8'h12, 1'b0);
    tick(5);
    chk("badstop_nferr", n_ferr, 1);
    chk("badstop_nsig", n_sig, 0);
    chk("badstop_rdata", rdata, 8'h3C);

    // Reset in the middle of a 0xFF frame's data bits.
    clear_mon();
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    chk("midrst_busy_before", rx_busy, 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midrst_rdata", rdata, 8'h00);
    chk("midrst_busy", rx_busy, 0);
    for (int i = 3; i < 8; i++) drive_bit(1'b1);
    drive_bit(1'b1);
    tick(5);
    chk("midrst_nsig", n_sig, 0);
    chk("midrst_nferr", n_ferr, 0);
    send_frame(8'h07, 1'b1);
    tick(5);
    chk("after_rst_nsig", n_sig, 1);
    chk("after_rst_rdata", rdata, 8'h07);

    // Break: line held low for 30 bit times.
    clear_mon();
    uart_rxd = 1'b0;
    tick(30 * CPB);
    chk("break_nferr", n_ferr, 1);
    chk("break_nsig", n_sig, 0);
    chk("break_busy", rx_busy, 0);
    uart_rxd = 1'b1;
    tick(40);
    chk("break_end_nferr", n_ferr, 1);
    chk("break_end_nsig", n_sig, 0);
    chk("break_end_busy", rx_busy, 0);
    chk("break_rdata", rdata, 8'h07);

    chk("never_both", n_both, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
